// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI data-memory responder: byte-enabled word SRAM model with programmable grant stall and
// response latency. Define CV32E40P_OBI_MEM_PARITY_EN for per-byte even parity with fault inject.
module cv32e40p_obi_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned GNT_STALL  = 0,
    parameter int unsigned RVALID_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        inj_i
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] widx;
    logic                  accept;
    logic                  stall_ok;
    logic [3:0]            stall_cnt_q, stall_cnt_d;
    logic                  rd_err;
    logic [31:0]           rsp_data;
    logic                  rsp_err;

    logic [RVALID_LAT-1:0]       vld_q, vld_d;
    logic [RVALID_LAT-1:0][31:0] data_q, data_d;
    logic [RVALID_LAT-1:0]       err_q, err_d;

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    assign widx = addr_i[ADDR_WIDTH+1:2];

    if (GNT_STALL == 0) begin : g_no_stall
        assign stall_ok = 1'b1;
    end else begin : g_stall
        assign stall_ok = ({28'd0, stall_cnt_q} >= GNT_STALL);
    end

    assign gnt_o  = req_i && stall_ok;
    assign accept = req_i && gnt_o;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!req_i || accept) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != 4'hF) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

`ifdef CV32E40P_OBI_MEM_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic [3:0] wr_par;
    logic [3:0] rd_par;

    // Stored bit is even parity of the byte, inverted on injected writes.
    always_comb begin
        wr_par = '0;
        rd_par = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            wr_par[k] = (^wdata_i[8*k +: 8]) ^ inj_i;
            rd_par[k] = ^mem[widx][8*k +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    par_mem[widx][k] <= wr_par[k];
                end
            end
        end
    end

    assign rd_err = |(rd_par ^ par_mem[widx]);
`else
    logic unused_inj;
    assign unused_inj = inj_i;
    assign rd_err     = 1'b0;
`endif

    // Idle slots and write responses carry zero data/err so outputs read 0 between responses.
    always_comb begin
        rsp_data = we_i ? '0 : mem[widx];
        rsp_err  = !we_i && rd_err;
        vld_d    = '0;
        data_d   = '0;
        err_d    = '0;
        vld_d[0]  = accept;
        data_d[0] = accept ? rsp_data : '0;
        err_d[0]  = accept && rsp_err;
        for (int unsigned i = 1; i < RVALID_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
            err_d[i]  = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            vld_q       <= '0;
            data_q      <= '0;
            err_q       <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign rvalid_o = vld_q[RVALID_LAT-1];
    assign rdata_o  = data_q[RVALID_LAT-1];
    assign err_o    = err_q[RVALID_LAT-1];

endmodule

// File: doc/cv32e40p_obi_mem_responder.md
Name: cv32e40p_obi_mem_responder

Overview:
- OBI responder (slave) for the core's data memory interface: answers core-side req/gnt/rvalid transactions from an internal byte-enabled word SRAM model.
- Used in core-level benches and the TMR/fault-injection lab top as the data memory behind the core's data port.
- Grant stall and response latency are programmable to exercise the core's LSU handshake corner cases.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words.
- GNT_STALL, 0, minimum cycles req_i must be pending before gnt_o asserts (0 = same-cycle grant).
- RVALID_LAT, 1, cycles from grant to rvalid_o (legal 1..8).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  32  byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  parity error, qualified by rvalid_o
- inj_i  in  1  fault inject: corrupt stored parity of bytes written this transaction

Behaviour:
- Transaction accepted on a rising edge where req_i && gnt_o.
- Stall counter, 4 bits:
  - Increments, saturating, each cycle req_i=1 && !gnt_o.
  - Clears to 0 on acceptance or when req_i=0.
  - gnt_o = req_i && (stall_cnt >= GNT_STALL). This is combinational, so with GNT_STALL=0 gnt_o follows req_i in the same cycle.
  - Back-to-back requests with GNT_STALL=0 are granted every cycle.
  - With GNT_STALL=N, every transaction waits N cycles after req_i rises or stays high after a grant.
- Addressing: word index = addr_i[ADDR_WIDTH+1:2]. Upper address bits are ignored (aliasing). addr_i[1:0] is ignored; the byte lanes come from be_i.
- Write on acceptance: byte k of the word is updated iff be_i[k]. be_i=0 is a legal no-op write and still gets a response.
- Read on acceptance: the word is sampled at the accept edge.
  - A read accepted the cycle after a write to the same word returns the new data.
  - Reads return all 32 bits regardless of be_i; the core performs lane extraction.
- Response pipeline: shift register of depth RVALID_LAT carrying {valid, we, data, err}.
  - rvalid_o rises exactly RVALID_LAT cycles after the accept edge.
  - Responses are strictly in order, one per accepted transaction.
  - No response back-pressure; the core always accepts rvalid.
  - rvalid_o is registered.
- Write responses: rvalid_o=1, rdata_o=0, err_o=0.
- Between responses (rvalid_o=0): rdata_o holds 0 and err_o holds 0.
- Outstanding transactions: up to RVALID_LAT in flight; no extra limit is imposed.
- Reset (asynchronous, any time):
  - rvalid_o=0, rdata_o=0, err_o=0, stall_cnt=0; gnt_o therefore 0 while req_i=0.
  - All in-flight responses are discarded.
  - Memory contents are not reset; power-up content is X unless preloaded by the bench via hierarchical $readmemh on the mem array.
- No state machine beyond the stall counter and pipeline; there is no idle/busy FSM because the responder is fully pipelined.

Optional Feature:
- Macro: CV32E40P_OBI_MEM_PARITY_EN.
- Enabled:
  - Each byte stores an even-parity bit (4 bits per word) written with the byte.
  - If inj_i=1 on a write accept, the stored parity of each enabled byte is inverted.
  - On a read accept, parity is recomputed over all 4 bytes; any mismatch sets err_o together with that read's rvalid_o.
  - Data is returned unmodified.
  - A later clean write to a byte clears its error.
- Disabled: no parity storage; err_o tied 0; inj_i ignored.
- The port list is identical in both builds.

Test Plan:
- GNT_STALL=0, RVALID_LAT=1: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 next cycle. Required: gnt in the same cycle as req each time; rvalid 1 cycle after each grant; read rdata=0xDEADBEEF.
- Byte enables: write 0xFFFFFFFF to 0x20 with be=4'hF, then 0x00000000 with be=4'b0101, then read. Required: rdata=0xFF00FF00.
- GNT_STALL=3: hold req_i high for a read of 0x10. Required: gnt_o low for 3 cycles, high on the 4th; rvalid_o 1 cycle after the grant.
- RVALID_LAT=3: issue 3 back-to-back reads to 0x0, 0x4, 0x8 preloaded with 1, 2, 3. Required: rvalid high for 3 consecutive cycles starting 3 cycles after the first grant; rdata 1, 2, 3 in order.
- Reset mid-flight: RVALID_LAT=4, assert rst_i 2 cycles after a grant. Required: rvalid_o=0 immediately and no late response after release; a write done before reset is still readable afterwards.
- Parity build: write 0x12345678 with be=4'hF and inj_i=1, then read it back. Required: rdata=0x12345678 with err_o=1. Then rewrite with inj_i=0 and read again. Required: err_o=0.
